// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: tap count, accumulator sizing and rounding helpers.
// Reused by the convolution engine and by later pooling/requant blocks.
package cnn_pkg;

    localparam int KTAPS      = 9;
    localparam int GUARD_BITS = 4;

    // Four guard bits hold nine full-width products plus a bias without overflow.
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + GUARD_BITS;
    endfunction

    // Round-half-up offset added before an arithmetic right shift.
    function automatic int round_half(input int shift);
        return (shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0;
    endfunction

endpackage

// File: rtl/conv_round_sat.sv
// Combinational round / shift / saturate / ReLU stage for an accumulator value.
// Assumes OUT_W <= ACC_W so the clip test always has at least one high bit to inspect.
module conv_round_sat
    import cnn_pkg::*;
#(
    parameter int SHIFT  = 0,
    parameter int SIGNED = 1,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16
)(
    input  logic [ACC_W-1:0] sum,
    input  logic             relu_en,
    output logic [OUT_W-1:0] value,
    output logic             sat
);
    // One extra bit keeps the rounding add from wrapping at the top of the range.
    localparam int EXT_W = ACC_W + 1;
    localparam logic [EXT_W-1:0] RND   = EXT_W'(round_half(SHIFT));
    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] U_MAX = {OUT_W{1'b1}};

    logic [EXT_W-1:0] ext_s;
    logic [EXT_W-1:0] rnd_s;
    logic [EXT_W-1:0] shf_arith_s;
    logic [EXT_W-1:0] shf_logic_s;
    logic [EXT_W-1:0] shf_s;
    logic             over_s;
    logic [OUT_W-1:0] clip_s;
    logic [OUT_W-1:0] sat_val_s;

    assign ext_s       = {(SIGNED != 0) & sum[ACC_W-1], sum};
    assign rnd_s       = ext_s + RND;
    assign shf_arith_s = $signed(rnd_s) >>> SHIFT;
    assign shf_logic_s = rnd_s >> SHIFT;
    assign shf_s       = (SIGNED != 0) ? shf_arith_s : shf_logic_s;

    // Signed fits iff all bits from the output sign bit upward agree.
    assign over_s = (SIGNED != 0)
                  ? ~((&shf_s[EXT_W-1:OUT_W-1]) | ~(|shf_s[EXT_W-1:OUT_W-1]))
                  : (|shf_s[EXT_W-1:OUT_W]);
    assign clip_s    = (SIGNED != 0) ? (shf_s[EXT_W-1] ? S_MIN : S_MAX) : U_MAX;
    assign sat_val_s = over_s ? clip_s : shf_s[OUT_W-1:0];

    assign value = ((SIGNED != 0) && relu_en && sat_val_s[OUT_W-1]) ? {OUT_W{1'b0}} : sat_val_s;
    assign sat   = over_s;

endmodule

// File: rtl/conv2d_pipe_mac9.sv
// Four-stage pipelined 3x3 convolution with stored kernel/bias and valid/ready back-pressure.
// Bias travels with each sample from S1 so a k_load never affects samples already accepted.
module conv2d_pipe_mac9
    import cnn_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  COEF_W = 8,
    parameter int  OUT_W  = 16,
    parameter int  SHIFT  = 0,
    parameter int  SIGNED = 1,
    localparam int ACC_W  = acc_width(DATA_W, COEF_W)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    k_load,
    input  logic [KTAPS*COEF_W-1:0] k_i,
    input  logic [ACC_W-1:0]        bias_i,
    input  logic                    relu_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [KTAPS*DATA_W-1:0] win_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_o,
    output logic                    sat_o
);
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int GUARD_W = ACC_W - PROD_W;

    logic [KTAPS*COEF_W-1:0] k_r;
    logic [ACC_W-1:0]        bias_r;
    logic [PROD_W-1:0]       a_s    [KTAPS];
    logic [PROD_W-1:0]       b_s    [KTAPS];
    logic [PROD_W-1:0]       prod_s [KTAPS];
    logic [PROD_W-1:0]       prod_r [KTAPS];
    logic [ACC_W-1:0]        bias1_r;
    logic [ACC_W-1:0]        bias2_r;
    logic [ACC_W-1:0]        pair_r [4];
    logic [ACC_W-1:0]        p8_r;
    logic [ACC_W-1:0]        sum_r;
    logic [OUT_W-1:0]        rs_value_s;
    logic                    rs_sat_s;
    logic [OUT_W-1:0]        out_r;
    logic                    sat_r;
    logic                    v1_r, v2_r, v3_r, v4_r;
    logic                    adv_s;

    function automatic logic [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
        return {{GUARD_W{(SIGNED != 0) & p[PROD_W-1]}}, p};
    endfunction

    assign adv_s     = ~v4_r | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = v4_r;
    assign out_o     = out_r;
    assign sat_o     = sat_r;

    // Extend both operands to product width; the low PROD_W bits of the product are then exact.
    always_comb begin
        for (int n = 0; n < KTAPS; n++) begin
            a_s[n]    = {{COEF_W{(SIGNED != 0) & win_i[n*DATA_W + DATA_W - 1]}}, win_i[n*DATA_W +: DATA_W]};
            b_s[n]    = {{DATA_W{(SIGNED != 0) & k_r[n*COEF_W + COEF_W - 1]}}, k_r[n*COEF_W +: COEF_W]};
            prod_s[n] = a_s[n] * b_s[n];
        end
    end

    conv_round_sat #(
        .SHIFT  (SHIFT),
        .SIGNED (SIGNED),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_round_sat (
        .sum     (sum_r),
        .relu_en (relu_en),
        .value   (rs_value_s),
        .sat     (rs_sat_s)
    );

    // Weight and bias store, loaded independently of the pipeline advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r    <= '0;
            bias_r <= '0;
        end else if (k_load) begin
            k_r    <= k_i;
            bias_r <= bias_i;
        end
    end

    // Pipeline stages S1..S4; every stage shifts together on adv and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            v3_r    <= 1'b0;
            v4_r    <= 1'b0;
            bias1_r <= '0;
            bias2_r <= '0;
            p8_r    <= '0;
            sum_r   <= '0;
            out_r   <= '0;
            sat_r   <= 1'b0;
            for (int n = 0; n < KTAPS; n++) prod_r[n] <= '0;
            for (int i = 0; i < 4; i++)     pair_r[i] <= '0;
        end else if (adv_s) begin
            v1_r    <= in_valid;
            bias1_r <= bias_r;
            for (int n = 0; n < KTAPS; n++) prod_r[n] <= prod_s[n];

            v2_r    <= v1_r;
            bias2_r <= bias1_r;
            p8_r    <= ext_prod(prod_r[8]);
            for (int i = 0; i < 4; i++) pair_r[i] <= ext_prod(prod_r[2*i]) + ext_prod(prod_r[2*i+1]);

            v3_r  <= v2_r;
            sum_r <= pair_r[0] + pair_r[1] + pair_r[2] + pair_r[3] + p8_r + bias2_r;

            v4_r  <= v3_r;
            out_r <= rs_value_s;
            sat_r <= rs_sat_s;
        end
    end

endmodule
